// File: rtl/pll_reconf_ctrl_if.sv
// pll_reconf_ctrl_if
//   Groups the signals between the PLL reconfiguration sequencer and its
//   surroundings: the mode-select logic, the reconfiguration ROM and the
//   ALTPLL reconfig core.
//
//   mode_in          requested mode code (level)
//   pll_reconf_busy  busy from the ALTPLL reconfig core
//   pll_locked       PLL lock, already synchronised to the sequencer clock
//   mode_out         mode code presented to the ROM
//   write_from_rom   one-cycle write strobe to the reconfig core
//   pll_areset       PLL asynchronous reset request
//   mode_active      last successfully applied mode
//   ctrl_busy        sequencer is working on a request
//   reconf_done      one-cycle success pulse
//   reconf_error     sticky failure flag
//
//   master: environment side (drives requests and PLL status)
//   slave : sequencer side
interface pll_reconf_ctrl_if;
  logic [7:0] mode_in;
  logic       pll_reconf_busy;
  logic       pll_locked;
  logic [7:0] mode_out;
  logic       write_from_rom;
  logic       pll_areset;
  logic [7:0] mode_active;
  logic       ctrl_busy;
  logic       reconf_done;
  logic       reconf_error;

  modport master (
    output mode_in, pll_reconf_busy, pll_locked,
    input  mode_out, write_from_rom, pll_areset, mode_active,
           ctrl_busy, reconf_done, reconf_error
  );

  modport slave (
    input  mode_in, pll_reconf_busy, pll_locked,
    output mode_out, write_from_rom, pll_areset, mode_active,
           ctrl_busy, reconf_done, reconf_error
  );
endinterface

// File: rtl/pll_reconf_ctrl.sv
// pll_reconf_ctrl
//   Runtime PLL reconfiguration sequencer. Qualifies a requested mode,
//   presents it to the reconfiguration ROM, strobes write_from_rom on the
//   ALTPLL reconfig core, tracks its busy handshake and waits for a stable
//   re-lock before declaring the new mode active.
//
//   clock    system clock
//   reset_n  asynchronous active-low reset
//   bus      pll_reconf_ctrl_if.slave (see interface file for signals)
//
//   Build option PLL_RECONF_LOCK_RETRY_EN: on a lock timeout, pulse
//   pll_areset and retry the lock wait up to MAX_RETRY times before failing.
//   Without it, a lock timeout fails immediately and pll_areset stays 0.
//
//   state        | meaning
//   IDLE         | requested mode equals active mode
//   STABLE       | waiting for mode_in to hold still
//   LOAD         | mode_out driven, letting the ROM outputs settle
//   WAIT_IDLE    | waiting for the reconfig core to be idle
//   WRITE        | write_from_rom strobe
//   WAIT_BUSY_HI | waiting for the core to acknowledge with busy
//   WAIT_BUSY_LO | waiting for the core to finish
//   WAIT_LOCK    | waiting for LOCK_STABLE consecutive lock cycles
//   ARESET       | pll_areset pulse before a lock retry (retry build only)
//   ERROR        | last attempt failed; waits for a different request
module pll_reconf_ctrl #(
  parameter int STABLE_CYCLES = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int BUSY_TIMEOUT  = 4096,
  parameter int LOCK_TIMEOUT  = 1048576,
  parameter int LOCK_STABLE   = 256,
  parameter int ARESET_CYCLES = 8,
  parameter int MAX_RETRY     = 3
) (
  input logic               clock,
  input logic               reset_n,
  pll_reconf_ctrl_if.slave  bus
);

  localparam int LW = $clog2(LOCK_STABLE + 1);

  localparam logic [23:0]   STABLE_LAST  = 24'(STABLE_CYCLES - 1);
  localparam logic [23:0]   SETTLE_LAST  = 24'(SETTLE_CYCLES - 1);
  localparam logic [23:0]   BUSY_LAST    = 24'(BUSY_TIMEOUT - 1);
  localparam logic [23:0]   LOCK_TO_LAST = 24'(LOCK_TIMEOUT - 1);
  localparam logic [LW-1:0] LOCK_LAST    = LW'(LOCK_STABLE - 1);

  // The retry counter is two bits wide.
  if (MAX_RETRY > 3 || ARESET_CYCLES < 1) begin : g_bad_cfg
    $error("pll_reconf_ctrl: MAX_RETRY must be <= 3 and ARESET_CYCLES >= 1");
  end

  typedef enum logic [3:0] {
    IDLE,
    STABLE,
    LOAD,
    WAIT_IDLE,
    WRITE,
    WAIT_BUSY_HI,
    WAIT_BUSY_LO,
    WAIT_LOCK,
`ifdef PLL_RECONF_LOCK_RETRY_EN
    ARESET,
`endif
    ERROR
  } state_t;

  state_t        state, state_nxt;
  logic [23:0]   cnt, cnt_nxt;
  logic          cnt_clr;
  logic [LW-1:0] lock_cnt, lock_cnt_nxt;
  logic [7:0]    req, req_nxt;
  logic [7:0]    mode_out_q, mode_out_nxt;
  logic [7:0]    mode_act_q, mode_act_nxt;
  logic          done_q, done_nxt;
  logic          err_q, err_nxt;
  logic          busy_seen, busy_seen_nxt;
  logic          lock_ok;
`ifdef PLL_RECONF_LOCK_RETRY_EN
  localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);
  logic [1:0]    retry, retry_nxt;
`endif

  assign lock_ok = bus.pll_locked && (lock_cnt == LOCK_LAST);

  always_comb begin
    state_nxt     = state;
    req_nxt       = req;
    mode_out_nxt  = mode_out_q;
    mode_act_nxt  = mode_act_q;
    done_nxt      = 1'b0;
    err_nxt       = err_q;
    lock_cnt_nxt  = lock_cnt;
    busy_seen_nxt = 1'b0;
    cnt_clr       = 1'b0;
`ifdef PLL_RECONF_LOCK_RETRY_EN
    retry_nxt     = retry;
`endif
    unique case (state)
      IDLE: begin
        if (bus.mode_in != mode_act_q) begin
          req_nxt   = bus.mode_in;
          state_nxt = STABLE;
        end
      end
      STABLE: begin
        if (bus.mode_in == mode_act_q) begin
          state_nxt = IDLE;
        end else if (bus.mode_in != req) begin
          req_nxt = bus.mode_in;
          cnt_clr = 1'b1;
        end else if (cnt == STABLE_LAST) begin
          mode_out_nxt = req;
          state_nxt    = LOAD;
`ifdef PLL_RECONF_LOCK_RETRY_EN
          retry_nxt    = 2'd0;
`endif
        end
      end
      LOAD: begin
        if (cnt == SETTLE_LAST) state_nxt = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (!bus.pll_reconf_busy) begin
          state_nxt = WRITE;
        end else if (cnt == BUSY_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = ERROR;
        end
      end
      WRITE: begin
        // A core that raises busy while the strobe is still high must not
        // be missed by the following acknowledge wait.
        busy_seen_nxt = bus.pll_reconf_busy;
        state_nxt     = WAIT_BUSY_HI;
      end
      WAIT_BUSY_HI: begin
        if (bus.pll_reconf_busy || busy_seen) begin
          state_nxt = WAIT_BUSY_LO;
        end else if (cnt == BUSY_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = ERROR;
        end
      end
      WAIT_BUSY_LO: begin
        if (!bus.pll_reconf_busy) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt == BUSY_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = ERROR;
        end
      end
      WAIT_LOCK: begin
        if (bus.pll_locked) lock_cnt_nxt = lock_cnt + 1'b1;
        else                lock_cnt_nxt = '0;
        if (lock_ok) begin
          mode_act_nxt = req;
          done_nxt     = 1'b1;
          err_nxt      = 1'b0;
          state_nxt    = IDLE;
        end else if (cnt == LOCK_TO_LAST) begin
`ifdef PLL_RECONF_LOCK_RETRY_EN
          if (retry < RETRY_MAX) begin
            retry_nxt = retry + 2'd1;
            state_nxt = ARESET;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = ERROR;
          end
`else
          err_nxt   = 1'b1;
          state_nxt = ERROR;
`endif
        end
      end
`ifdef PLL_RECONF_LOCK_RETRY_EN
      ARESET: begin
        if (cnt == 24'(ARESET_CYCLES - 1)) state_nxt = WAIT_LOCK;
      end
`endif
      ERROR: begin
        if (bus.mode_in != req) begin
          req_nxt   = bus.mode_in;
          err_nxt   = 1'b0;
          state_nxt = STABLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != state) begin
      cnt_clr      = 1'b1;
      lock_cnt_nxt = '0;
    end
    cnt_nxt = cnt_clr ? 24'd0 : cnt + 24'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      lock_cnt   <= '0;
      req        <= 8'hFF;
      mode_out_q <= 8'hFF;
      mode_act_q <= 8'hFF;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_seen  <= 1'b0;
`ifdef PLL_RECONF_LOCK_RETRY_EN
      retry      <= 2'd0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      lock_cnt   <= lock_cnt_nxt;
      req        <= req_nxt;
      mode_out_q <= mode_out_nxt;
      mode_act_q <= mode_act_nxt;
      done_q     <= done_nxt;
      err_q      <= err_nxt;
      busy_seen  <= busy_seen_nxt;
`ifdef PLL_RECONF_LOCK_RETRY_EN
      retry      <= retry_nxt;
`endif
    end
  end

  assign bus.mode_out       = mode_out_q;
  assign bus.mode_active    = mode_act_q;
  assign bus.write_from_rom = (state == WRITE);
  assign bus.ctrl_busy      = (state != IDLE) && (state != ERROR);
  assign bus.reconf_done    = done_q;
  assign bus.reconf_error   = err_q;
`ifdef PLL_RECONF_LOCK_RETRY_EN
  assign bus.pll_areset     = (state == ARESET);
`else
  assign bus.pll_areset     = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reconf_ctrl.sv
// tb_pll_reconf_ctrl
//   Directed bench for pll_reconf_ctrl. A small reconfig-core/PLL model
//   answers every write_from_rom with a busy pulse and a later lock; a
//   negedge monitor records strobes, areset pulses and error timing.
//   LOCK_TIMEOUT is shortened so the lock-failure paths finish quickly.
module tb_pll_reconf_ctrl;
  localparam int LOCK_TO = 1024;

  logic clock = 1'b0;
  logic reset_n;

  pll_reconf_ctrl_if bus();

  pll_reconf_ctrl #(
    .STABLE_CYCLES(16), .SETTLE_CYCLES(4), .BUSY_TIMEOUT(4096),
    .LOCK_TIMEOUT(LOCK_TO), .LOCK_STABLE(256), .ARESET_CYCLES(8),
    .MAX_RETRY(3)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reconfig core and PLL model.
  int busy_len = 40;
  int lock_dly = 100;
  bit model_act = 1'b0;

  initial begin
    bus.pll_reconf_busy = 1'b0;
    bus.pll_locked      = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.write_from_rom) begin
        model_act      = 1'b1;
        bus.pll_locked = 1'b0;
        repeat (2) @(negedge clock);
        bus.pll_reconf_busy = 1'b1;
        repeat (busy_len) @(negedge clock);
        bus.pll_reconf_busy = 1'b0;
        if (lock_dly >= 0) begin
          repeat (lock_dly) @(negedge clock);
          bus.pll_locked = 1'b1;
        end
        model_act = 1'b0;
      end
    end
  end

  // Output monitor.
  int         cyc = 0, wr_cnt = 0, dn_cnt = 0, viol = 0;
  int         ar_cnt = 0, ar_bad = 0, ar_run = 0;
  int         mo_age = 0, mo_age_wr = 0, last_wr_cyc = 0, err_rise_cyc = 0;
  logic [7:0] wr_modes [64];
  logic [7:0] prev_mo = 8'h00;
  logic       prev_wr = 1'b0, prev_dn = 1'b0, prev_err = 1'b0;

  always @(negedge clock) begin
    cyc     <= cyc + 1;
    mo_age  <= (bus.mode_out !== prev_mo) ? 0 : mo_age + 1;
    prev_mo <= bus.mode_out;
    if (bus.write_from_rom) begin
      wr_modes[wr_cnt % 64] <= bus.mode_out;
      wr_cnt                <= wr_cnt + 1;
      mo_age_wr             <= (bus.mode_out !== prev_mo) ? 0 : mo_age + 1;
      last_wr_cyc           <= cyc;
    end
    if (bus.reconf_done) dn_cnt <= dn_cnt + 1;
    if ((bus.write_from_rom && bus.reconf_done) || (bus.write_from_rom && prev_wr) ||
        (bus.reconf_done && prev_dn))
      viol <= viol + 1;
    if (bus.pll_areset) begin
      ar_run <= ar_run + 1;
    end else begin
      if (ar_run != 0) begin
        ar_cnt <= ar_cnt + 1;
        if (ar_run != 8) ar_bad <= ar_bad + 1;
      end
      ar_run <= 0;
    end
    if (bus.reconf_error && !prev_err) err_rise_cyc <= cyc;
    prev_wr  <= bus.write_from_rom;
    prev_dn  <= bus.reconf_done;
    prev_err <= bus.reconf_error;
  end

  task automatic wait_settled(input int budget, output bit ok);
    int quiet;
    quiet = 0;
    ok    = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clock);
      if (!bus.ctrl_busy && !model_act) quiet++;
      else quiet = 0;
      if (quiet >= 4) ok = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mode_out"},    32'(bus.mode_out),       32'hFF);
    check({tag, "_mode_active"}, 32'(bus.mode_active),    32'hFF);
    check({tag, "_write"},       32'(bus.write_from_rom), 32'h0);
    check({tag, "_areset"},      32'(bus.pll_areset),     32'h0);
    check({tag, "_ctrl_busy"},   32'(bus.ctrl_busy),      32'h0);
    check({tag, "_done"},        32'(bus.reconf_done),    32'h0);
    check({tag, "_error"},       32'(bus.reconf_error),   32'h0);
  endtask

  typedef struct {
    logic [7:0] mode;
    logic       use_glitch;
    logic [7:0] glitch_alt;
    logic [7:0] exp_active;
    int         exp_writes;
    int         exp_dones;
  } vec_t;

  vec_t vecs [4];

  initial begin
    bit ok;
    int wr0, dn0, ar0, arb0;

    vecs[0] = '{8'h01, 1'b0, 8'h00, 8'h01, 1, 1};   // first request after reset
    vecs[1] = '{8'h03, 1'b1, 8'h02, 8'h03, 1, 1};   // glitchy 02/03 request
    vecs[2] = '{8'h03, 1'b0, 8'h00, 8'h03, 0, 0};   // already active: nothing to do
    vecs[3] = '{8'h7A, 1'b0, 8'h00, 8'h7A, 1, 1};

    reset_n     = 1'b0;
    bus.mode_in = 8'h01;
    repeat (3) @(negedge clock);
    check_reset_outputs("por");
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      wr0 = wr_cnt;
      dn0 = dn_cnt;
      if (vecs[i].use_glitch) begin
        for (int t = 0; t < 6; t++) begin
          bus.mode_in = (t % 2 == 0) ? vecs[i].glitch_alt : vecs[i].mode;
          repeat (5) @(negedge clock);
        end
        check($sformatf("v%0d_glitch_no_write", i), 32'(wr_cnt - wr0), 32'd0);
      end
      bus.mode_in = vecs[i].mode;
      wait_settled(2000, ok);
      check($sformatf("v%0d_settled", i), 32'(ok), 32'd1);
      check($sformatf("v%0d_mode_active", i), 32'(bus.mode_active), 32'(vecs[i].exp_active));
      check($sformatf("v%0d_writes", i), 32'(wr_cnt - wr0), 32'(vecs[i].exp_writes));
      check($sformatf("v%0d_dones", i), 32'(dn_cnt - dn0), 32'(vecs[i].exp_dones));
      check($sformatf("v%0d_error", i), 32'(bus.reconf_error), 32'd0);
      check($sformatf("v%0d_ctrl_busy", i), 32'(bus.ctrl_busy), 32'd0);
      if (vecs[i].exp_writes > 0) begin
        check($sformatf("v%0d_mode_at_write", i), 32'(wr_modes[(wr_cnt - 1) % 64]),
              32'(vecs[i].mode));
        check($sformatf("v%0d_mode_out_lead_ge4", i), 32'(mo_age_wr >= 4), 32'd1);
      end
    end

    // Request change while the 02 sequence sits in WAIT_BUSY_LO.
    wr0 = wr_cnt;
    dn0 = dn_cnt;
    bus.mode_in = 8'h02;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clock);
      if (bus.pll_reconf_busy) ok = 1'b1;
    end
    check("midseq_busy_seen", 32'(ok), 32'd1);
    repeat (5) @(negedge clock);
    bus.mode_in = 8'h04;
    wait_settled(3000, ok);
    check("midseq_settled", 32'(ok), 32'd1);
    check("midseq_writes", 32'(wr_cnt - wr0), 32'd2);
    check("midseq_dones", 32'(dn_cnt - dn0), 32'd2);
    check("midseq_first_mode", 32'(wr_modes[wr0 % 64]), 32'h02);
    check("midseq_second_mode", 32'(wr_modes[(wr0 + 1) % 64]), 32'h04);
    check("midseq_mode_active", 32'(bus.mode_active), 32'h04);

    // Busy stuck high: WAIT_BUSY_LO times out after 4096 cycles.
    busy_len    = 5000;
    bus.mode_in = 8'h05;
    ok = 1'b0;
    for (int n = 0; n < 6000 && !ok; n++) begin
      @(negedge clock);
      if (bus.reconf_error) ok = 1'b1;
    end
    check("stuck_error_set", 32'(ok), 32'd1);
    check("stuck_mode_active", 32'(bus.mode_active), 32'h04);
    check("stuck_ctrl_busy", 32'(bus.ctrl_busy), 32'd0);
    ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clock);
      if (!model_act) ok = 1'b1;
    end
    check("stuck_model_released", 32'(ok), 32'd1);
    // write seen at cycle k; busy sampled high at k+3; 4096 cycles in WAIT_BUSY_LO
    check("stuck_error_delay", 32'(err_rise_cyc - last_wr_cyc), 32'd4099);
    busy_len    = 40;
    bus.mode_in = 8'h06;
    @(negedge clock);
    check("stuck_error_cleared", 32'(bus.reconf_error), 32'd0);
    wait_settled(2000, ok);
    check("stuck_recover_settled", 32'(ok), 32'd1);
    check("stuck_recover_active", 32'(bus.mode_active), 32'h06);

    // Lock never reached.
    lock_dly    = -1;
    ar0         = ar_cnt;
    arb0        = ar_bad;
    bus.mode_in = 8'h07;
    ok = 1'b0;
    for (int n = 0; n < 6000 && !ok; n++) begin
      @(negedge clock);
      if (bus.reconf_error) ok = 1'b1;
    end
    check("nolock_error_set", 32'(ok), 32'd1);
    @(negedge clock);
    check("nolock_mode_active", 32'(bus.mode_active), 32'h06);
    check("nolock_areset_bad_width", 32'(ar_bad - arb0), 32'd0);
`ifdef PLL_RECONF_LOCK_RETRY_EN
    check("nolock_areset_pulses", 32'(ar_cnt - ar0), 32'd3);
    // 43 cycles to WAIT_LOCK, then 4 lock waits of 1024 and 3 aresets of 8
    check("nolock_error_delay", 32'(err_rise_cyc - last_wr_cyc), 32'd4163);
`else
    check("nolock_areset_pulses", 32'(ar_cnt - ar0), 32'd0);
    check("nolock_error_delay", 32'(err_rise_cyc - last_wr_cyc), 32'd1067);
`endif
    lock_dly    = 100;
    bus.mode_in = 8'h08;
    wait_settled(2000, ok);
    check("nolock_recover_settled", 32'(ok), 32'd1);
    check("nolock_recover_active", 32'(bus.mode_active), 32'h08);
    check("nolock_recover_error", 32'(bus.reconf_error), 32'd0);

    // Reset asserted while waiting for a stable lock.
    wr0 = wr_cnt;
    bus.mode_in = 8'h09;
    ok = 1'b0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clock);
      if (wr_cnt != wr0 && bus.pll_locked) ok = 1'b1;
    end
    check("rst_reached_lock_wait", 32'(ok), 32'd1);
    repeat (50) @(negedge clock);
    check("rst_busy_before", 32'(bus.ctrl_busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    wr0 = wr_cnt;
    wait_settled(2000, ok);
    check("rst_rerun_settled", 32'(ok), 32'd1);
    check("rst_rerun_writes", 32'(wr_cnt - wr0), 32'd1);
    check("rst_rerun_active", 32'(bus.mode_active), 32'h09);

    check("strobe_overlap_or_repeat", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached after %0d tests", tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pll_reconf_ctrl.md
Name: pll_reconf_ctrl

Overview:
Sequences a full runtime PLL reconfiguration: qualifies a requested video mode, presents it to the PLL reconfiguration ROM, and pulses `write_from_rom` on the ALTPLL reconfig core. It then tracks reconfig-core busy and waits for the PLL to re-lock stably. It sits between the mode-select logic and the ROM/reconfig-core pair, and reports which mode is active and whether the last attempt failed.

Parameters:
- STABLE_CYCLES, 16: cycles `mode_in` must hold unchanged before a sequence starts.
- SETTLE_CYCLES, 4: cycles between driving `mode_out` and pulsing `write_from_rom`. Covers the ROM latch and its delayed outputs.
- BUSY_TIMEOUT, 4096: max cycles spent in each busy-wait state.
- LOCK_TIMEOUT, 1048576: max cycles waiting for `pll_locked`.
- LOCK_STABLE, 256: consecutive cycles `pll_locked` must be high to count as locked.
- ARESET_CYCLES, 8: width of the `pll_areset` pulse (optional feature only).
- MAX_RETRY, 3: retries after a lock timeout (optional feature only).

Ports:
- clock, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- mode_in, in, 8: requested mode code; a level signal, not a strobe.
- pll_reconf_busy, in, 1: busy from the ALTPLL reconfig core.
- pll_locked, in, 1: PLL lock, already synchronised to `clock`.
- mode_out, out, 8: mode code driven to the ROM data input.
- write_from_rom, out, 1: one-cycle pulse to the reconfig core.
- pll_areset, out, 1: PLL async reset request.
- mode_active, out, 8: last successfully applied mode.
- ctrl_busy, out, 1: high in every state except IDLE and ERROR.
- reconf_done, out, 1: one-cycle pulse on success.
- reconf_error, out, 1: sticky failure flag.

Behaviour:
- Reset values: `mode_out`=8'hFF, `mode_active`=8'hFF, all 1-bit outputs 0, state IDLE, counters 0.
- A single 24-bit cycle counter is shared by all states and cleared on every state transition. A separate 2-bit retry counter is used.
- State transitions:
  - IDLE: if `mode_in != mode_active`, capture `req=mode_in` and go to STABLE.
  - STABLE: if `mode_in != req`, recapture `req` and clear the counter. Once the counter reaches STABLE_CYCLES-1, go to LOAD. If `mode_in` returns to `mode_active`, go back to IDLE with no reconfig.
  - LOAD: `mode_out<=req`. After SETTLE_CYCLES, go to WAIT_IDLE.
  - WAIT_IDLE: wait for `pll_reconf_busy`=0, then go to WRITE.
  - WRITE: `write_from_rom`=1 for exactly one cycle, then go to WAIT_BUSY_HI.
  - WAIT_BUSY_HI: wait for busy=1 (this cycle included), then go to WAIT_BUSY_LO.
  - WAIT_BUSY_LO: wait for busy=0, then go to WAIT_LOCK.
  - WAIT_LOCK: count consecutive `pll_locked` cycles; any low cycle resets the stable count. After LOCK_STABLE consecutive highs: `mode_active<=req`, pulse `reconf_done`, clear `reconf_error`, go to IDLE.
  - ERROR: `mode_active` stays at its old value. Leave ERROR only when `mode_in` differs from the failed `req`; then clear `reconf_error` and go to STABLE.
- Timeouts:
  - Counter reaching BUSY_TIMEOUT in WAIT_IDLE, WAIT_BUSY_HI or WAIT_BUSY_LO: set `reconf_error`, go to ERROR.
  - Counter reaching LOCK_TIMEOUT in WAIT_LOCK: handled by the optional feature.
- A `mode_in` change from LOAD through WAIT_LOCK is ignored. The sequence completes first, and IDLE then re-evaluates `mode_in`.
- `reconf_done` and `write_from_rom` are never high together, and never high for two consecutive cycles.
- Reset asserted mid-sequence aborts immediately to reset values. After release, `mode_active`=8'hFF, so a fresh sequence runs for any valid `mode_in`.
- Busy high in the same cycle as the WRITE pulse counts as WAIT_BUSY_HI satisfied on the next cycle.

Optional Feature:
- Macro: PLL_RECONF_LOCK_RETRY_EN.
- When defined: a LOCK_TIMEOUT expiry with retry<MAX_RETRY increments retry and goes to ARESET. ARESET holds `pll_areset`=1 for ARESET_CYCLES, then returns to WAIT_LOCK with the counter cleared. With retry==MAX_RETRY, go to ERROR. Retry is cleared on entry to LOAD.
- When undefined: LOCK_TIMEOUT goes straight to ERROR. `pll_areset` is tied 0 and the retry counter and ARESET state are absent.

Test Plan:
- Basic reconfig:
  - Stimulus: release reset with `mode_in`=8'h01; model busy high 40 cycles starting 2 cycles after `write_from_rom`; `pll_locked` high 100 cycles later.
  - Required response: exactly one `write_from_rom` pulse; `mode_out`=8'h01 at least 4 cycles before that pulse; one `reconf_done`; `mode_active`=8'h01; `ctrl_busy` low afterwards.
- Glitchy request:
  - Stimulus: `mode_in` toggles 8'h02↔8'h03 every 5 cycles, then settles at 8'h03.
  - Required response: no `write_from_rom` until 16 stable cycles; a single sequence for 8'h03.
- Request during sequence:
  - Stimulus: change to 8'h04 while in WAIT_BUSY_LO for 8'h02.
  - Required response: 8'h02 completes with `reconf_done`; a second sequence then applies 8'h04.
- Busy stuck high:
  - Stimulus: hold busy at 1 for 5000 cycles.
  - Required response: `reconf_error`=1 after 4096 cycles in WAIT_BUSY_LO; `mode_active` unchanged; a new `mode_in` clears the error and restarts.
- Lock never reached:
  - Stimulus: hold `pll_locked`=0.
  - Required response with PLL_RECONF_LOCK_RETRY_EN: 3 `pll_areset` pulses, each 8 cycles wide, then ERROR.
  - Required response without it: ERROR immediately after LOCK_TIMEOUT, with `pll_areset` never high.
- Reset mid-sequence:
  - Stimulus: assert `reset_n`=0 during WAIT_LOCK.
  - Required response: outputs return to reset values immediately, without waiting for a clock edge; after release the sequence re-runs for the current `mode_in`.
